// File: rtl/motor_pwm_drive_if.sv
// motor_pwm_drive_if: command handshake between a motion controller and the PWM drive.
interface motor_pwm_drive_if #(parameter int DUTY_W = 16);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_dir;
   logic [DUTY_W-1:0] cmd_duty;
   modport master (output cmd_valid, cmd_dir, cmd_duty, input cmd_ready);
   modport slave  (input cmd_valid, cmd_dir, cmd_duty, output cmd_ready);
endinterface

// File: rtl/motor_pwm_drive.sv
// motor_pwm_drive: H-bridge PWM with duty ramping, reversal dead-time and sticky fault shutdown.
module motor_pwm_drive #(
   parameter int PWM_PERIOD = 5000,
   parameter int DUTY_W     = 16,
   parameter int RAMP_STEP  = 50,
   parameter int RAMP_DIV   = 100000,
   parameter int DEADTIME   = 10000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   motor_pwm_drive_if.slave  cmd,
   input  logic              pos_fault,
   input  logic              fault_clr,
   output logic              pwm,
   output logic              dir,
   output logic              coast,
   output logic [DUTY_W-1:0] duty_now,
   output logic              busy,
   output logic              fault
);
   localparam int TW = $clog2(RAMP_DIV + 1);
   localparam int DW = $clog2(DEADTIME + 1);
   localparam logic [DUTY_W-1:0] PER  = DUTY_W'(PWM_PERIOD);
   localparam logic [DUTY_W-1:0] STEP = DUTY_W'(RAMP_STEP);

   typedef enum logic [2:0] {IDLE, RUN, RAMP_DOWN, DEAD, FAULT} state_t;
   state_t state_q, state_d;
   logic [DUTY_W-1:0] cnt_q, cnt_d, applied_q, applied_d, duty_q, duty_d;
   logic [DUTY_W-1:0] target_q, target_d, goal_q, goal_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [DW-1:0] dead_q, dead_d;
   logic pwm_q, pwm_d, dir_q, dir_d, coast_q, coast_d, pend_dir_q, pend_dir_d, fault_q, fault_d;
   logic accept, wrap, tick, up;
   logic [DUTY_W-1:0] diff, step, clamp;

   // rst_n gates ready so the handshake is closed while reset is held
   assign cmd.cmd_ready = rst_n && enable && !fault_q && !pos_fault && (state_q == IDLE || state_q == RUN);
   assign accept = cmd.cmd_valid && cmd.cmd_ready;
   assign wrap   = cnt_q == PER - DUTY_W'(1);
   assign tick   = tick_q == TW'(RAMP_DIV - 1);
   assign clamp  = cmd.cmd_duty > PER ? PER : cmd.cmd_duty;
   assign up     = goal_q > duty_q;
   assign diff   = up ? goal_q - duty_q : duty_q - goal_q;
   assign step   = diff > STEP ? STEP : diff;

   always_comb begin
      state_d    = state_q;
      cnt_d      = wrap ? '0 : cnt_q + DUTY_W'(1);
      tick_d     = tick ? '0 : tick_q + TW'(1);
      duty_d     = tick ? (up ? duty_q + step : duty_q - step) : duty_q;
      target_d   = target_q;
      goal_d     = goal_q;
      dir_d      = dir_q;
      coast_d    = coast_q;
      pend_dir_d = pend_dir_q;
      fault_d    = fault_q;
      dead_d     = dead_q;
      case (state_q)
         IDLE, RUN: begin
            if (accept && cmd.cmd_dir == dir_q) begin
               target_d = clamp;
               goal_d   = clamp;
               state_d  = RUN;
               coast_d  = 1'b0;
            end else if (accept) begin
               // target doubles as the pending duty until the reversal completes
               target_d   = clamp;
               pend_dir_d = cmd.cmd_dir;
               goal_d     = '0;
               dead_d     = '0;
               state_d    = duty_q != '0 ? RAMP_DOWN : DEAD;
               coast_d    = duty_q == '0;
            end else if (state_q == RUN && target_q == '0 && duty_q == '0) begin
               state_d = IDLE;
               coast_d = 1'b1;
            end
         end
         RAMP_DOWN: begin
            if (duty_q == '0) begin
               state_d = DEAD;
               coast_d = 1'b1;
               dead_d  = '0;
            end
         end
         DEAD: begin
            if (dead_q == DW'(DEADTIME - 1)) begin
               state_d = RUN;
               dir_d   = pend_dir_q;
               goal_d  = target_q;
               coast_d = 1'b0;
            end else begin
               dead_d = dead_q + DW'(1);
            end
         end
         FAULT: begin
            if (fault_clr && !pos_fault) begin
               state_d = IDLE;
               fault_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (!enable && state_q != FAULT) begin
         state_d  = IDLE;
         duty_d   = '0;
         target_d = '0;
         goal_d   = '0;
         coast_d  = 1'b1;
      end
      if (pos_fault) begin
         state_d  = FAULT;
         fault_d  = 1'b1;
         coast_d  = 1'b1;
         duty_d   = '0;
         target_d = '0;
         goal_d   = '0;
      end
      // clearing the applied duty while coasting avoids a stale pulse after reversal
      applied_d = coast_d ? '0 : wrap ? duty_q : applied_q;
      pwm_d     = !coast_d && cnt_q < applied_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         tick_q     <= '0;
         dead_q     <= '0;
         applied_q  <= '0;
         duty_q     <= '0;
         target_q   <= '0;
         goal_q     <= '0;
         pwm_q      <= 1'b0;
         dir_q      <= 1'b0;
         coast_q    <= 1'b1;
         pend_dir_q <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tick_q     <= tick_d;
         dead_q     <= dead_d;
         applied_q  <= applied_d;
         duty_q     <= duty_d;
         target_q   <= target_d;
         goal_q     <= goal_d;
         pwm_q      <= pwm_d;
         dir_q      <= dir_d;
         coast_q    <= coast_d;
         pend_dir_q <= pend_dir_d;
         fault_q    <= fault_d;
      end
   end

   assign pwm      = pwm_q;
   assign dir      = dir_q;
   assign coast    = coast_q;
   assign duty_now = duty_q;
   assign fault    = fault_q;
   assign busy     = state_q == RAMP_DOWN || state_q == DEAD || duty_q != goal_q;
endmodule

// File: tb/tb_motor_pwm_drive.sv
// tb_motor_pwm_drive: directed bench for the PWM drive with PERIOD=10, STEP=2, DIV=4, DEADTIME=8.
module tb_motor_pwm_drive;
   localparam int DW = 16;
   logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, pos_fault = 1'b0, fault_clr = 1'b0;
   logic pwm, dir, coast, busy, fault;
   logic [DW-1:0] duty_now;
   int checks = 0, failures = 0;

   motor_pwm_drive_if #(.DUTY_W(DW)) cmd ();

   motor_pwm_drive #(.PWM_PERIOD(10), .DUTY_W(DW), .RAMP_STEP(2), .RAMP_DIV(4), .DEADTIME(8)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .cmd(cmd), .pos_fault(pos_fault),
      .fault_clr(fault_clr), .pwm(pwm), .dir(dir), .coast(coast), .duty_now(duty_now),
      .busy(busy), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic send(input logic d, input logic [DW-1:0] v);
      int n = 0;
      @(negedge clk);
      cmd.cmd_valid = 1'b1;
      cmd.cmd_dir   = d;
      cmd.cmd_duty  = v;
      #1;
      while (!cmd.cmd_ready && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("accept_in_time", 32'(n < 100), 1);
      @(negedge clk);
      cmd.cmd_valid = 1'b0;
   endtask

   task automatic wait_change(output logic [DW-1:0] v, output int n);
      logic [DW-1:0] p = duty_now;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (duty_now == p && n < 40);
      v = duty_now;
   endtask

   task automatic wait_val(input logic [DW-1:0] v, input string tag);
      int n = 0;
      while (duty_now != v && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(tag, duty_now, v);
   endtask

   task automatic count_pwm(output int h);
      h = 0;
      repeat (10) begin
         @(negedge clk);
         h += int'(pwm);
      end
   endtask

   initial begin
      logic [DW-1:0] v;
      int n, h, run, runs, last;
      bit ok;
      cmd.cmd_valid = 1'b0;
      cmd.cmd_dir   = 1'b0;
      cmd.cmd_duty  = '0;
      repeat (3) @(negedge clk);
      check("rst_pwm", pwm, 0);
      check("rst_dir", dir, 0);
      check("rst_coast", coast, 1);
      check("rst_duty", duty_now, 0);
      check("rst_busy", busy, 0);
      check("rst_fault", fault, 0);
      check("rst_ready", cmd.cmd_ready, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_ready", cmd.cmd_ready, 1);

      // 1: first command reverses from dir 0, so it passes through dead-time
      send(1'b1, 16'd6);
      check("t1_dead_busy", busy, 1);
      check("t1_dead_ready", cmd.cmd_ready, 0);
      n = 0;
      while (coast && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("t1_coast_len", n, 8);
      check("t1_dir", dir, 1);
      wait_change(v, n);
      check("t1_step2", v, 2);
      wait_change(v, n);
      check("t1_step4", v, 4);
      check("t1_gap4", n, 4);
      wait_change(v, n);
      check("t1_step6", v, 6);
      check("t1_gap6", n, 4);
      check("t1_busy_done", busy, 0);
      check("t1_coast_off", coast, 0);
      repeat (20) @(negedge clk);
      count_pwm(h);
      check("t1_pwm_high6", h, 6);

      // 2: clamp to full period, then ramp to zero and fall back to IDLE
      send(1'b1, 16'd50);
      wait_val(16'd10, "t2_clamp_reach");
      repeat (8) @(negedge clk);
      check("t2_clamp_hold", duty_now, 10);
      repeat (20) @(negedge clk);
      count_pwm(h);
      check("t2_pwm_full", h, 10);
      send(1'b1, 16'd0);
      wait_val(16'd0, "t2_ramp_zero");
      repeat (2) @(negedge clk);
      check("t2_idle_coast", coast, 1);
      check("t2_idle_ready", cmd.cmd_ready, 1);
      check("t2_idle_busy", busy, 0);
      count_pwm(h);
      check("t2_pwm_low", h, 0);

      // 3: reversal while running
      send(1'b1, 16'd6);
      wait_val(16'd6, "t3_run6");
      send(1'b0, 16'd4);
      check("t3_rd_ready", cmd.cmd_ready, 0);
      check("t3_rd_busy", busy, 1);
      wait_change(v, n);
      check("t3_down4", v, 4);
      wait_change(v, n);
      check("t3_down2", v, 2);
      check("t3_down2_gap", n, 4);
      wait_change(v, n);
      check("t3_down0", v, 0);
      check("t3_rd_ready0", cmd.cmd_ready, 0);
      n = 0;
      while (!coast && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t3_dead_dir_hold", dir, 1);
      check("t3_dead_ready", cmd.cmd_ready, 0);
      n = 0;
      while (coast && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("t3_coast_len", n, 8);
      check("t3_dir_new", dir, 0);
      check("t3_run_ready", cmd.cmd_ready, 1);
      wait_change(v, n);
      check("t3_up2", v, 2);
      wait_change(v, n);
      check("t3_up4", v, 4);
      check("t3_settled", busy, 0);

      // 4: duty change mid-period; every complete pulse must be an old or new width
      send(1'b0, 16'd8);
      n = 0;
      while (pwm && n < 20) begin
         @(negedge clk);
         n++;
      end
      run = 0;
      runs = 0;
      last = 0;
      ok = 1'b1;
      repeat (80) begin
         @(negedge clk);
         if (pwm) run++;
         else if (run > 0) begin
            ok = ok && (run == 4 || run == 6 || run == 8);
            last = run;
            runs++;
            run = 0;
         end
      end
      check("t4_no_runt", 32'(ok), 1);
      check("t4_final_width", last, 8);
      check("t4_enough_runs", 32'(runs >= 6), 1);

      // 5: sticky fault
      send(1'b0, 16'd6);
      wait_val(16'd6, "t5_run6");
      @(negedge clk);
      pos_fault = 1'b1;
      #1;
      check("t5_ready_drop", cmd.cmd_ready, 0);
      @(negedge clk);
      check("t5_fault", fault, 1);
      check("t5_pwm", pwm, 0);
      check("t5_coast", coast, 1);
      check("t5_duty", duty_now, 0);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      check("t5_clr_ignored", fault, 1);
      pos_fault = 1'b0;
      @(negedge clk);
      check("t5_still_fault", fault, 1);
      check("t5_fault_ready", cmd.cmd_ready, 0);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      check("t5_cleared", fault, 0);
      check("t5_idle_ready", cmd.cmd_ready, 1);

      // 6: enable drop mid-ramp keeps dir; reset mid-period clears everything at once
      send(1'b1, 16'd8);
      wait_val(16'd4, "t6_mid_ramp");
      enable = 1'b0;
      @(negedge clk);
      check("t6_en_duty", duty_now, 0);
      check("t6_en_pwm", pwm, 0);
      check("t6_en_coast", coast, 1);
      check("t6_en_dir", dir, 1);
      check("t6_en_ready", cmd.cmd_ready, 0);
      enable = 1'b1;
      send(1'b1, 16'd10);
      wait_val(16'd10, "t6_full");
      repeat (15) @(negedge clk);
      check("t6_pwm_high", pwm, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_pwm", pwm, 0);
      check("t6_rst_dir", dir, 0);
      check("t6_rst_duty", duty_now, 0);
      check("t6_rst_coast", coast, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
